min_scan_controller: RTL and testbench

//  Sequencer for the push-button "smallest of N" datapath feeding the LCD.
//  - Debounces the load buttons and captures the holder switches into N slot registers.
//  - After each load, walks all slots through one shared comparator, one slot per cycle.
//  - Publishes the minimum value, its index and its ASCII code for the LCD line driver.

---
 rtl/min_scan_pkg.sv | 12 +
 rtl/pb_debounce.sv | 43 ++++
 rtl/min_scan_controller.sv | 138 +++++++++++++
 tb/tb_min_scan_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/min_scan_pkg.sv
// Shared types and constants for the smallest-of-N scan controller.
package min_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/pb_debounce.sv
// One push button: 2-flop synchronizer, saturating debounce counter and a
// single-cycle press pulse that does not repeat while the button is held.
module pb_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_i,
    output logic press_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DB_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires on the cycle the counter steps onto DB_CYCLES; saturation blocks repeats.
    assign press_o = sync2_q && (cnt_q == CW'(DB_CYCLES - 1));

endmodule

// File: rtl/min_scan_controller.sv
// Loads debounced button presses into slot registers, then walks the slots
// through one shared less-than comparator to publish the minimum for the LCD.
module min_scan_controller
    import min_scan_pkg::*;
#(
    parameter int N_SLOTS   = 4,
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SLOTS-1:0]         pb,
    input  logic [WIDTH-1:0]           holder,
    output logic [N_SLOTS*WIDTH-1:0]   slots,
    output logic [WIDTH-1:0]           min_val,
    output logic [$clog2(N_SLOTS)-1:0] min_idx,
    output logic [7:0]                 min_char,
    output logic                       busy,
    output logic                       done,
    output logic                       valid
);

    localparam int IW = $clog2(N_SLOTS);

    logic [N_SLOTS-1:0] press;
    logic [WIDTH-1:0]   slot_q [N_SLOTS];

    scan_state_e        state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   best_q, best_d;
    logic [IW-1:0]      best_idx_q, best_idx_d;
    logic [WIDTH-1:0]   min_val_q, min_val_d;
    logic [IW-1:0]      min_idx_q, min_idx_d;
    logic               valid_q, valid_d;
    logic               pending_q, pending_d;

    logic [WIDTH-1:0]   cand;
    logic               cand_lt;
    logic               take;
    logic [WIDTH-1:0]   next_best;
    logic [IW-1:0]      next_best_idx;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_db
        pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .pb_i    (pb[g]),
            .press_o (press[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (press[i]) slot_q[i] <= holder;
            end
        end
    end

    always_comb begin
        slots = '0;
        for (int i = 0; i < N_SLOTS; i++) slots[i*WIDTH +: WIDTH] = slot_q[i];
    end

    // The single shared comparator; slot 0 seeds the running best unconditionally.
    assign cand          = slot_q[idx_q];
    assign cand_lt       = cand < best_q;
    assign take          = (idx_q == '0) || cand_lt;
    assign next_best     = take ? cand  : best_q;
    assign next_best_idx = take ? idx_q : best_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            min_val_q  <= '0;
            min_idx_q  <= '0;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            min_val_q  <= min_val_d;
            min_idx_q  <= min_idx_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        min_val_d  = min_val_q;
        min_idx_d  = min_idx_q;
        valid_d    = valid_q;
        pending_d  = pending_q | (|press);
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    pending_d = |press;
                end
            end
            SCAN: begin
                best_d     = next_best;
                best_idx_d = next_best_idx;
                if (idx_q == IW'(N_SLOTS - 1)) begin
                    // Result registers load on entry to DONE so they are stable during the pulse.
                    state_d   = DONE;
                    min_val_d = next_best;
                    min_idx_d = next_best_idx;
                    valid_d   = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign min_val  = min_val_q;
    assign min_idx  = min_idx_q;
    assign min_char = ASCII_ZERO + 8'(min_val_q);
    assign busy     = (state_q == SCAN);
    assign done     = (state_q == DONE);
    assign valid    = valid_q;

endmodule

// File: tb/tb_min_scan_controller.sv
// Scoreboard bench for min_scan_controller: stimulus pushes expected scan
// results, a monitor pops and compares them on every done pulse.
module tb_min_scan_controller;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pb;
    logic [W-1:0] holder;
    logic [N*W-1:0] slots;
    logic [W-1:0] min_val;
    logic [1:0]   min_idx;
    logic [7:0]   min_char;
    logic         busy;
    logic         done;
    logic         valid;

    int n_cmp = 0;
    int n_err = 0;

    // expected {min_idx, min_val} for each done pulse, in order
    logic [5:0] exp_q[$];
    logic [W-1:0] ref_slots [N];

    min_scan_controller #(.N_SLOTS(N), .WIDTH(W), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .pb       (pb),
        .holder   (holder),
        .slots    (slots),
        .min_val  (min_val),
        .min_idx  (min_idx),
        .min_char (min_char),
        .busy     (busy),
        .done     (done),
        .valid    (valid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] ref_min();
        int m = 1 << W;
        int k = 0;
        foreach (ref_slots[i]) if (int'(ref_slots[i]) < m) m = int'(ref_slots[i]);
        for (int i = N - 1; i >= 0; i--) if (int'(ref_slots[i]) == m) k = i;
        return {2'(k), 4'(m)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with min_val=%0d min_idx=%0d, required none",
                         min_val, min_idx);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("done_result {valid,char,idx,val}",
                      {17'd0, valid, min_char, min_idx, min_val},
                      {17'd0, 1'b1, 8'h30 + {4'd0, e[3:0]}, e[5:4], e[3:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [N-1:0] mask, input logic [W-1:0] val);
        for (int i = 0; i < N; i++) if (mask[i]) ref_slots[i] = val;
        exp_q.push_back(ref_min());
        tick(1);
        holder = val;
        pb     = mask;
        tick(9);
        pb = '0;
        tick(3);
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    task automatic check_slots(input string tag);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_slot%0d", tag, i), {28'd0, slots[i*W +: W]}, {28'd0, ref_slots[i]});
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_slots"},   {16'd0, slots}, 32'd0);
        check({tag, "_min_val"}, {28'd0, min_val}, 32'd0);
        check({tag, "_min_idx"}, {30'd0, min_idx}, 32'd0);
        check({tag, "_min_char"}, {24'd0, min_char}, 32'h30);
        check({tag, "_flags"},   {29'd0, busy, done, valid}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit busy_seen;
        int cyc;
        rst    = 1'b1;
        pb     = '0;
        holder = '0;
        foreach (ref_slots[i]) ref_slots[i] = '0;
        tick(3);
        rst = 1'b0;
        check_reset_outputs("reset");
        tick(20);

        // directed load 7,3,9,5
        press(4'b0001, 4'd7); drain();
        press(4'b0010, 4'd3); drain();
        press(4'b0100, 4'd9); drain();
        press(4'b1000, 4'd5); drain();
        check_slots("load7395");

        // two-cycle glitch must not load or scan
        tick(1);
        holder = 4'd1;
        pb     = 4'b0100;
        tick(2);
        pb = '0;
        busy_seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("glitch_no_scan", {31'd0, busy_seen}, 32'd0);
        check_slots("glitch");

        // tie: 4,2,2,6 -> index 1
        press(4'b0001, 4'd4); drain();
        press(4'b0010, 4'd2); drain();
        press(4'b0100, 4'd2); drain();
        press(4'b1000, 4'd6); drain();
        check_slots("tie");

        // pb[1] reload (holder 2), then pb[3] with holder 0 lands mid-scan -> two dones
        ref_slots[1] = 4'd2;
        ref_slots[3] = 4'd0;
        exp_q.push_back(ref_min());
        exp_q.push_back(ref_min());
        tick(1);
        holder = 4'd2;
        pb     = 4'b0010;
        tick(3);
        pb     = 4'b1010;
        tick(4);
        holder = 4'd0;
        tick(4);
        pb = '0;
        tick(3);
        drain();
        check_slots("overlap");

        // randomized single and multi-button loads
        for (int it = 0; it < 12; it++) begin
            logic [N-1:0] mask;
            logic [W-1:0] val;
            mask = (it < 6) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom_range(1, (1 << N) - 1));
            val  = W'($urandom_range(0, (1 << W) - 1));
            press(mask, val);
            drain();
        end
        check_slots("random");

        // simultaneous pb[0]/pb[1] with holder 8, then reset mid-scan
        ref_slots[0] = 4'd8;
        ref_slots[1] = 4'd8;
        tick(1);
        holder = 4'd8;
        pb     = 4'b0011;
        cyc = 0;
        while (!busy && cyc < 60) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL busy_timeout: got busy=0, required busy=1 within 60 cycles");
        end
        check_slots("simul");
        tick(1);
        rst = 1'b1;
        pb  = '0;
        check_reset_outputs("mid_scan_rst");
        tick(2);
        rst = 1'b0;
        foreach (ref_slots[i]) ref_slots[i] = '0;
        tick(20);
        check_reset_outputs("after_rst");

        check("results_left", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
